// File: rtl/glip_uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// glip_uart_rx_sampler
//
// Serial receive front end of the UART backend. Synchronises the
// asynchronous rx line, detects start bits, and samples every bit with a
// 3-tap majority vote around mid-bit. Each good 8N1 frame is delivered as a
// single-cycle enable pulse with the byte on data; a low stop bit produces a
// single-cycle error pulse instead. There is no backpressure.
//
// Parameters:
//   DIVISOR  clk cycles per bit (>= 8); HALF = DIVISOR/2
//
// Ports:
//   clk     receive clock (clk_io domain)
//   rst     asynchronous active-low reset (0 = reset)
//   rx      asynchronous UART line, idle high
//   enable  one-cycle pulse, data holds a valid received byte
//   data    received byte, LSB first on the line; holds between pulses
//   error   one-cycle pulse on framing error
//   busy    high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module glip_uart_rx_sampler #(
  parameter int DIVISOR = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       enable,
  output logic [7:0] data,
  output logic       error,
  output logic       busy
);

  localparam int HALF = DIVISOR / 2;
  localparam int CW   = $clog2(DIVISOR);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
  // The third vote tap is rx_sync_r itself in this cycle.
  localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_START      = 3'd1;
  localparam logic [2:0] ST_DATA       = 3'd2;
  localparam logic [2:0] ST_STOP       = 3'd3;
  localparam logic [2:0] ST_BREAK_WAIT = 3'd4;

  // 2-of-3 majority of the three mid-bit samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic          rx_meta_r;
  logic          rx_sync_r;
  logic [2:0]    state_r;
  logic [2:0]    state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic [2:0]    bit_idx_r;
  logic [2:0]    bit_idx_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_s;
  logic [1:0]    smp_r;
  logic [1:0]    smp_s;
  logic [7:0]    data_r;
  logic [7:0]    data_s;
  logic          enable_r;
  logic          enable_s;
  logic          error_r;
  logic          error_s;
  logic          busy_r;
  logic          is_dec_s;
  logic          vote_s;

  assign is_dec_s = (cnt_r == CNT_DEC);
  assign vote_s   = maj3(smp_r[0], smp_r[1], rx_sync_r);

  // Two-flop synchroniser for the asynchronous rx line (idle high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Next-state, sampling and output decode for the frame receiver.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    smp_s     = smp_r;
    data_s    = data_r;
    enable_s  = 1'b0;
    error_s   = 1'b0;

    // Capture the two early vote taps; cnt stays 0 in IDLE so nothing fires there.
    if (cnt_r == CNT_S0) begin
      smp_s[0] = rx_sync_r;
    end else if (cnt_r == CNT_S1) begin
      smp_s[1] = rx_sync_r;
    end else begin
      smp_s = smp_r;
    end

    // Free-running bit timer while a bit is being timed; wraps at DIVISOR-1.
    if ((state_r == ST_START) || (state_r == ST_DATA) || (state_r == ST_STOP)) begin
      if (cnt_r == CNT_LAST) begin
        cnt_s = CNT_ZERO;
      end else begin
        cnt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_s = CNT_ZERO;
    end

    case (state_r)
      ST_IDLE: begin
        if (!rx_sync_r) begin
          state_s = ST_START;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (is_dec_s && vote_s) begin
          // Line came back high by mid-bit: glitch, not a start bit.
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_s   = ST_DATA;
          cnt_s     = CNT_ZERO;
          bit_idx_s = 3'd0;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (is_dec_s) begin
          // Right shift so the first (LSB) bit ends at bit 0 after eight bits.
          shift_s = {vote_s, shift_r[7:1]};
        end else begin
          shift_s = shift_r;
        end
        if (cnt_r == CNT_LAST) begin
          cnt_s = CNT_ZERO;
          if (bit_idx_r == 3'd7) begin
            state_s = ST_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        // Leave at mid stop bit: half a bit of margin to catch the next start.
        if (is_dec_s) begin
          cnt_s = CNT_ZERO;
          if (vote_s) begin
            data_s   = shift_r;
            enable_s = 1'b1;
            state_s  = ST_IDLE;
          end else begin
            error_s = 1'b1;
            state_s = ST_BREAK_WAIT;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_BREAK_WAIT: begin
        // Hold off until the line is idle again (break or stuck-low line).
        if (rx_sync_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      smp_r     <= 2'b00;
      data_r    <= 8'h00;
      enable_r  <= 1'b0;
      error_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      smp_r     <= smp_s;
      data_r    <= data_s;
      enable_r  <= enable_s;
      error_r   <= error_s;
      busy_r    <= (state_s != ST_IDLE);
    end
  end

  assign enable = enable_r;
  assign data   = data_r;
  assign error  = error_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_glip_uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// Testbench for glip_uart_rx_sampler. The line waveform of each frame is
// built cycle by cycle in an array; a reference model reads the expected
// byte, outcome and pulse time straight from that waveform and pushes it to
// a scoreboard queue which a separate monitor drains on every pulse.
// ---------------------------------------------------------------------------
module tb_glip_uart_rx_sampler;

  localparam int D    = 16;
  localparam int HALF = D / 2;
  localparam int WMAX = 256;
  localparam int HMAX = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       enable;
  logic       error;
  logic       busy;
  logic [7:0] data;

  glip_uart_rx_sampler #(.DIVISOR(D)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .enable(enable), .data(data), .error(error), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] d;
    int         t;
  } exp_t;
  exp_t exp_q[$];

  logic       wave [0:WMAX-1];
  int         wlen = 0;
  logic       busy_hist [0:HMAX-1];
  logic [7:0] last_data = 8'h00;
  bit         prev_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic wave_at(input int j);
    if (j < wlen) return wave[j];
    return 1'b1;
  endfunction

  // Line value seen at counter value c of frame bit k is wave[D*k + c + 1]
  // (input flop + synchroniser); vote taps are c = HALF-1, HALF, HALF+1.
  function automatic logic vote_bit(input int k);
    int j;
    int ones;
    j = D * k + HALF;
    ones = int'(wave_at(j)) + int'(wave_at(j + 1)) + int'(wave_at(j + 2));
    return (ones >= 2) ? 1'b1 : 1'b0;
  endfunction

  // Frame driven from the cycle after edge p: the line is first sampled low
  // at edge p+1 and the result pulse follows edge p+1+4+9*D+HALF.
  task automatic predict(input int p);
    exp_t e;
    logic [7:0] d;
    if (vote_bit(0)) return;
    for (int k = 0; k < 8; k++) d[k] = vote_bit(k + 1);
    e.is_err = ~vote_bit(9);
    e.d      = d;
    e.t      = p + 5 + 9 * D + HALF;
    exp_q.push_back(e);
  endtask

  task automatic build_frame(input logic [7:0] d, input logic stop);
    wlen = 10 * D;
    for (int j = 0; j < wlen; j++) begin
      if (j < D) wave[j] = 1'b0;
      else if (j >= 9 * D) wave[j] = stop;
      else wave[j] = d[j / D - 1];
    end
  endtask

  task automatic drive(input int n, input bit push_exp, output int p);
    @(posedge clk);
    #1;
    p = cyc;
    if (push_exp) predict(p);
    for (int j = 0; j < n; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
      end
      rx = wave[j];
    end
  endtask

  // Monitor: record busy every cycle and score every pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cyc < HMAX) busy_hist[cyc] = busy;
      if (rst && (enable || error)) begin
        check("pulse_exclusive", {31'd0, enable & error}, 32'd0);
        check("pulse_not_consecutive", {31'd0, prev_pulse}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: enable=%0b error=%0b data=%0h at cycle %0d",
                   enable, error, data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind_error", {31'd0, error}, {31'd0, e.is_err});
          check("pulse_time", cyc, e.t);
          if (e.is_err) begin
            check("data_hold_on_error", {24'd0, data}, {24'd0, last_data});
          end else begin
            check("data", {24'd0, data}, {24'd0, e.d});
            last_data = e.d;
          end
        end
      end
      prev_pulse = rst && (enable || error);
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    logic [7:0] rb;

    // Reset state.
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_enable", {31'd0, enable}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", {24'd0, data}, 32'd0);
    rst = 1'b1;
    repeat (5) @(posedge clk);

    // Clean frame 8'hA5, latency and busy boundaries.
    build_frame(8'hA5, 1'b1);
    drive(wlen, 1'b1, p);
    repeat (10) @(posedge clk);
    check("a5_busy_before_start", {31'd0, busy_hist[p + 2]}, 32'd0);
    check("a5_busy_start", {31'd0, busy_hist[p + 3]}, 32'd1);
    check("a5_busy_last", {31'd0, busy_hist[p + 156]}, 32'd1);
    check("a5_busy_done", {31'd0, busy_hist[p + 157]}, 32'd0);

    // Back-to-back frames with no idle gap.
    build_frame(8'h00, 1'b1);
    drive(wlen, 1'b1, p);
    build_frame(8'hFF, 1'b1);
    drive(wlen, 1'b1, p);
    build_frame(8'h55, 1'b1);
    drive(wlen, 1'b1, p);
    repeat (20) @(posedge clk);

    // Framing error followed by a held-low line.
    build_frame(8'h3C, 1'b0);
    for (int j = 10 * D; j < 10 * D + 40; j++) wave[j] = 1'b0;
    for (int j = 10 * D + 40; j < 10 * D + 48; j++) wave[j] = 1'b1;
    wlen = 10 * D + 48;
    drive(wlen, 1'b1, p);
    repeat (10) @(posedge clk);
    check("brk_busy_at_error", {31'd0, busy_hist[p + 157]}, 32'd1);
    check("brk_busy_held", {31'd0, busy_hist[p + 180]}, 32'd1);
    check("brk_busy_last", {31'd0, busy_hist[p + 202]}, 32'd1);
    check("brk_busy_idle", {31'd0, busy_hist[p + 203]}, 32'd0);

    // Three-cycle low glitch: start abandoned at the decision cycle.
    wlen = 30;
    for (int j = 0; j < wlen; j++) wave[j] = (j < 3) ? 1'b0 : 1'b1;
    drive(wlen, 1'b1, p);
    repeat (5) @(posedge clk);
    check("glitch_busy_before", {31'd0, busy_hist[p + 2]}, 32'd0);
    check("glitch_busy_start", {31'd0, busy_hist[p + 3]}, 32'd1);
    check("glitch_busy_decide", {31'd0, busy_hist[p + 12]}, 32'd1);
    check("glitch_busy_idle", {31'd0, busy_hist[p + 13]}, 32'd0);

    // Single-cycle spike on the centre vote tap of every data bit.
    build_frame(8'h96, 1'b1);
    for (int k = 1; k <= 8; k++) wave[D * k + HALF + 1] = ~wave[D * k + HALF + 1];
    drive(wlen, 1'b1, p);
    repeat (10) @(posedge clk);

    // Reset during data bit 4; frame must vanish without a pulse.
    build_frame(8'h5A, 1'b1);
    drive(5 * D + 4, 1'b0, p);
    #2;
    rst = 1'b0;
    rx  = 1'b1;
    last_data = 8'h00;
    #1;
    check("midrst_enable", {31'd0, enable}, 32'd0);
    check("midrst_error", {31'd0, error}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_data", {24'd0, data}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    build_frame(8'h81, 1'b1);
    drive(wlen, 1'b1, p);
    repeat (10) @(posedge clk);

    // Random bytes with random idle gaps (including none).
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      build_frame(rb, 1'b1);
      drive(wlen, 1'b1, p);
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    repeat (5) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/glip_uart_rx_sampler.md
Name: glip_uart_rx_sampler

Overview:
- Serial receive front end of the UART backend. Sits directly upstream of the UART control/ingress stage and feeds it one byte per valid 8N1 frame.
- Synchronises the asynchronous rx line, detects start bits, and samples each bit with a 3-tap majority vote around mid-bit.
- Delivers each byte as a single-cycle enable pulse with data, and flags framing errors to the sticky error logic.
- Has no backpressure: the consumer must accept a byte on every enable pulse.

Parameters:
DIVISOR, 16, clk cycles per bit (FREQ/BAUD, truncated); legal range DIVISOR >= 8; HALF = DIVISOR/2 (integer division)

Ports:
clk  input  1  receive clock (clk_io domain)
rst  input  1  asynchronous, active-low reset (0 = reset)
rx  input  1  asynchronous UART line, idle high
enable  output  1  one-cycle pulse: data holds a valid received byte
data  output  8  received byte, LSB received first; holds last value between pulses
error  output  1  one-cycle pulse on framing error
busy  output  1  high while a frame is in progress (any state other than IDLE)

Behaviour:
- Reset (rst=0, asynchronous):
  - Both synchroniser flops = 1.
  - state = IDLE; bit counter = 0; bit index = 0; shift register = 0.
  - enable = 0, error = 0, data = 8'h00, busy = 0.
- Synchroniser: two flip-flops; rx_s is the second stage. All decisions use rx_s only.
- Bit counter cnt:
  - Width $clog2(DIVISOR).
  - Cleared on every state entry; increments each cycle while in START/DATA/STOP.
  - Wraps to 0 at DIVISOR-1.
- Majority vote: rx_s is captured at cnt = HALF-1, HALF and HALF+1. The vote (>= 2 of 3 ones -> 1) is evaluated at cnt = HALF+1, called the decision cycle.
- States:
  - IDLE: rx_s == 0 -> START; cnt = 0.
  - START:
    - Decision cycle, vote = 1: false start (glitch) -> IDLE. No pulse.
    - cnt = DIVISOR-1 -> DATA; bit index = 0.
  - DATA:
    - Decision cycle: vote shifted into the shift register MSB, right-shift, so the first bit ends up at bit 0.
    - cnt = DIVISOR-1: if bit index = 7 -> STOP, else bit index + 1.
  - STOP, decision cycle:
    - vote = 1: data <= shift register, enable <= 1 for exactly one cycle -> IDLE. Early return gives half a bit of resync margin.
    - vote = 0: error <= 1 for one cycle; data unchanged; no enable -> BREAK_WAIT.
  - BREAK_WAIT: stays until rx_s == 1 -> IDLE. Covers a line held low or a break.
- Latency: let E be the first clk edge at which the first synchroniser flop samples rx low. The START state registers at edge E+2. enable (or error) is high during the cycle following edge E+4+9*DIVISOR+HALF.
- enable and error are registered, mutually exclusive, and never high for two consecutive cycles.
- Back-to-back frames: a start bit that follows immediately after the stop-bit decision is detected from IDLE with no lost frame.
- Reset mid-frame: the frame is discarded and no pulse is produced. After release the block sees rx idle; if rx is low at release, a start is detected normally and the frame is processed.
- busy = (state != IDLE), registered with the state.

Test Plan:
- DIVISOR=16; send 8'hA5 at exactly 16 clk/bit -> one enable pulse, data=8'hA5, error never high; enable in the cycle after edge E+156.
- Frames 8'h00, 8'hFF, 8'h55 back-to-back with no idle gap -> three enable pulses, data 00, FF, 55 in order; no error.
- Frame 8'h3C with stop bit driven 0, then rx held low 40 cycles, then high -> error pulse exactly once at stop-bit decision, no enable, busy stays 1 until rx_s high, then IDLE.
- rx low glitch of 3 cycles, then idle -> START entered then abandoned at decision; no enable, no error; busy returns 0.
- Single-cycle spike inverting the sample at cnt=HALF in each data bit of 8'h96 -> majority vote recovers data=8'h96.
- rst asserted during data bit 4 of a frame, released 10 cycles later with rx high -> all outputs 0 immediately; no pulse; the next clean frame 8'h81 is received correctly.
